pc_register: RTL and testbench



---
 rtl/pc_register.sv | 29 ++
 tb/tb_pc_register.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc_register.sv
// Program counter register for the datapath. Each clock edge it clears, loads a jump/branch target,
// increments, or holds. Clear has the highest priority, then load, then increment.
module pc_register #(
    parameter int                    ADDR_WIDTH  = 21,
    parameter logic [ADDR_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  PC_Clr,
    input  logic                  PC_Load,
    input  logic                  PC_Inc,
    input  logic [ADDR_WIDTH-1:0] Dest_Reg,
    output logic [ADDR_WIDTH-1:0] PC_Out
);

    // The increment wraps modulo 2^ADDR_WIDTH, and there is no overflow indication.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            PC_Out <= RESET_VALUE;
        end else if (PC_Clr) begin
            PC_Out <= RESET_VALUE;
        end else if (PC_Load) begin
            PC_Out <= Dest_Reg;
        end else if (PC_Inc) begin
            PC_Out <= PC_Out + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pc_register.sv
// Directed and randomised checks of pc_register: async reset, increment/hold, load,
// Clr > Load > Inc priority, wrap-around, and a 1000-cycle reference-model run.
module tb_pc_register;

    localparam int W = 21;
    localparam logic [W-1:0] MASK = {W{1'b1}};

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         PC_Clr;
    logic         PC_Load;
    logic         PC_Inc;
    logic [W-1:0] Dest_Reg;
    logic [W-1:0] PC_Out;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 Clk = ~Clk;

    pc_register #(.ADDR_WIDTH(W), .RESET_VALUE('0)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .PC_Clr   (PC_Clr),
        .PC_Load  (PC_Load),
        .PC_Inc   (PC_Inc),
        .Dest_Reg (Dest_Reg),
        .PC_Out   (PC_Out)
    );

    task automatic check_value(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
        end
    endtask

    // Drive controls on the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic clr, input logic load, input logic inc, input logic [W-1:0] dest);
        @(negedge Clk);
        PC_Clr   = clr;
        PC_Load  = load;
        PC_Inc   = inc;
        Dest_Reg = dest;
        @(posedge Clk);
        #1;
    endtask

    logic [W-1:0] ref_pc;
    logic         r_clr, r_load, r_inc;
    logic [W-1:0] r_dest;

    initial begin
        Rst_n    = 1'b0;
        PC_Clr   = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        Dest_Reg = '0;
        #2;
        check_value("reset_state", PC_Out, 21'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Asynchronous reset in mid-cycle, then held low with a pending load.
        apply(1'b0, 1'b1, 1'b0, 21'h00123);
        check_value("preload_123", PC_Out, 21'h00123);
        @(negedge Clk);
        PC_Load  = 1'b1;
        Dest_Reg = 21'h00ABC;
        Rst_n    = 1'b0;
        #1;
        check_value("async_reset_now", PC_Out, 21'h0);
        @(posedge Clk); #1;
        check_value("reset_hold_edge1", PC_Out, 21'h0);
        @(posedge Clk); #1;
        check_value("reset_hold_edge2", PC_Out, 21'h0);
        @(negedge Clk);
        Rst_n   = 1'b1;
        PC_Load = 1'b0;

        // Increment five times, then hold three.
        for (int i = 1; i <= 5; i++) begin
            apply(1'b0, 1'b0, 1'b1, 21'h0);
            check_value($sformatf("inc_%0d", i), PC_Out, W'(i));
        end
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 1'b0, 21'h1F0F0);
            check_value($sformatf("hold_%0d", i), PC_Out, 21'h5);
        end

        // Load then increment.
        apply(1'b0, 1'b1, 1'b0, 21'h0F0F0);
        check_value("load_0f0f0", PC_Out, 21'h0F0F0);
        apply(1'b0, 1'b0, 1'b1, 21'h12345);
        check_value("inc_after_load", PC_Out, 21'h0F0F1);
        apply(1'b0, 1'b1, 1'b0, 21'h0F0F1);
        check_value("load_same_value", PC_Out, 21'h0F0F1);

        // Priority checks.
        apply(1'b1, 1'b1, 1'b1, 21'h00055);
        check_value("prio_clr_all", PC_Out, 21'h0);
        apply(1'b0, 1'b1, 1'b1, 21'h00055);
        check_value("prio_load_over_inc", PC_Out, 21'h00055);
        apply(1'b1, 1'b0, 1'b0, 21'h0);
        check_value("clr_only", PC_Out, 21'h0);

        // Wrap-around at full width.
        apply(1'b0, 1'b1, 1'b0, 21'h1FFFFF);
        check_value("load_max", PC_Out, 21'h1FFFFF);
        apply(1'b0, 1'b0, 1'b1, 21'h0);
        check_value("wrap_to_zero", PC_Out, 21'h0);

        // Randomised run against a priority reference model.
        ref_pc = PC_Out === 21'h0 ? 21'h0 : 21'h0;
        for (int c = 0; c < 1000; c++) begin
            r_clr  = ($urandom_range(0, 9) == 0);
            r_load = ($urandom_range(0, 3) == 0);
            r_inc  = ($urandom_range(0, 1) == 1);
            r_dest = W'($urandom) & MASK;
            if (r_clr)       ref_pc = 21'h0;
            else if (r_load) ref_pc = r_dest;
            else if (r_inc)  ref_pc = ref_pc + 21'h1;
            apply(r_clr, r_load, r_inc, r_dest);
            check_value($sformatf("rand_%0d", c), PC_Out, ref_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
